// File: rtl/inst_sram_axi_bridge_if.sv
// rtl/inst_sram_axi_bridge_if.sv - fetch-port and AXI read-channel bundle for inst_sram_axi_bridge
interface inst_sram_axi_bridge_if;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   // bridge view
   modport slave (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   // environment view: IF stage plus AXI slave
   modport master (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// rtl/inst_sram_axi_bridge.sv - read-only SRAM-like fetch port to single-beat AXI read bridge (option: INST_BRIDGE_RDATA_REG_EN)
module inst_sram_axi_bridge #(
   parameter int         MAX_OUTSTANDING = 2,
   parameter logic [3:0] AXI_ID          = 4'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   inst_sram_axi_bridge_if.slave bus
);

   localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);

   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_SEND = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   araddr_q, araddr_d;
   logic [1:0]    size_q, size_d;

   logic addr_ok;
   logic data_ok;
   logic r_take;

   // Acceptance is blocked while an AR is pending or the in-flight budget is used up;
   // reset gates it so nothing is accepted while the core is still held.
   assign addr_ok = ~reset & bus.inst_sram_req & (state_q == AR_IDLE) & (cnt_q < MAX_CNT);

   // A beat only counts when something is outstanding, so a stray beat is drained
   // without ever underflowing the counter.
   assign r_take = bus.rvalid & bus.rready & (cnt_q != '0);

`ifdef INST_BRIDGE_RDATA_REG_EN
   logic        buf_full_q, buf_full_d;
   logic [31:0] buf_data_q, buf_data_d;

   assign bus.rready          = ~buf_full_q;
   assign data_ok             = buf_full_q;
   assign bus.inst_sram_rdata = buf_data_q;

   // One-entry return buffer: filled on a counted beat, emptied on the following cycle.
   always_comb begin
      buf_full_d = buf_full_q;
      buf_data_d = buf_data_q;
      if (buf_full_q) begin
         buf_full_d = 1'b0;
      end else if (r_take) begin
         buf_full_d = 1'b1;
         buf_data_d = bus.rdata;
      end
   end

   // Return buffer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_full_q <= 1'b0;
         buf_data_q <= '0;
      end else begin
         buf_full_q <= buf_full_d;
         buf_data_q <= buf_data_d;
      end
   end
`else
   assign bus.rready          = 1'b1;
   assign data_ok             = r_take;
   assign bus.inst_sram_rdata = reset ? 32'h0 : bus.rdata;
`endif

   assign bus.inst_sram_addr_ok = addr_ok;
   assign bus.inst_sram_data_ok = data_ok;

   assign bus.arid    = AXI_ID;
   assign bus.araddr  = araddr_q;
   assign bus.arlen   = 8'd0;
   assign bus.arsize  = {1'b0, size_q};
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'b0000;
   assign bus.arprot  = 3'b000;
   assign bus.arvalid = (state_q == AR_SEND);

   logic unused_inputs;
   assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                            bus.rid, bus.rresp, bus.rlast};

   // AR channel: capture the request on acceptance and hold it until arready.
   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      size_d   = size_q;
      case (state_q)
         AR_IDLE: begin
            if (addr_ok) begin
               state_d  = AR_SEND;
               araddr_d = bus.inst_sram_addr;
               size_d   = bus.inst_sram_size;
            end
         end
         AR_SEND: begin
            if (bus.arready) begin
               state_d = AR_IDLE;
            end
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // Outstanding count: accepted requests whose data_ok has not yet been given.
   always_comb begin
      cnt_d = cnt_q;
      case ({addr_ok, data_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // AR state, latched request and outstanding count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= AR_IDLE;
         araddr_q <= '0;
         size_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         size_q   <= size_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// tb/tb_inst_sram_axi_bridge.sv - self-checking bench for inst_sram_axi_bridge
module tb_inst_sram_axi_bridge;
   localparam int MAX = 2;
`ifdef INST_BRIDGE_RDATA_REG_EN
   localparam bit REG_MODE = 1'b1;
`else
   localparam bit REG_MODE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_sram_axi_bridge_if bus ();

   inst_sram_axi_bridge #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { logic [31:0] addr; logic [1:0] size; } req_t;
   typedef struct { logic [31:0] addr; int t; } beat_t;

   req_t  acc_q[$];
   beat_t r_pend[$];
   bit          m_busy;
   logic [31:0] m_ar_addr;
   logic [1:0]  m_ar_size;
   bit          m_buf_full;
   bit          acc_now;
   int cyc, ar_stall, r_lat, n_coincide;
   int n_tests, n_fail;

   function automatic logic [31:0] mem(logic [31:0] a);
      if (a == 32'h1c00_0000) return 32'h02c0_0000;
      return (a * 32'h9e37_79b1) ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(bit r, logic [31:0] a, logic [1:0] s);
      bus.inst_sram_req   = r;
      bus.inst_sram_addr  = a;
      bus.inst_sram_size  = s;
      bus.inst_sram_wr    = 1'($urandom);
      bus.inst_sram_wstrb = 4'($urandom);
      bus.inst_sram_wdata = $urandom;
   endtask

   task automatic tick();
      bit exp_aok, exp_dok, exp_rrdy, rhs, was_full;
      @(negedge clk);
      exp_aok  = bus.inst_sram_req && !m_busy && (acc_q.size() < MAX);
      exp_rrdy = REG_MODE ? !m_buf_full : 1'b1;
      exp_dok  = REG_MODE ? m_buf_full : (bus.rvalid && acc_q.size() > 0);
      chk("addr_ok", bus.inst_sram_addr_ok, exp_aok);
      chk("arvalid", bus.arvalid, m_busy);
      chk("rready", bus.rready, exp_rrdy);
      chk("data_ok", bus.inst_sram_data_ok, exp_dok);
      if (m_busy) begin
         chk("araddr", bus.araddr, m_ar_addr);
         chk("arsize", bus.arsize, {1'b0, m_ar_size});
         chk("ar_fixed", {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
             {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
      end
      if (exp_dok && acc_q.size() > 0)
         chk("rdata_order", bus.inst_sram_rdata, mem(acc_q[0].addr));

      acc_now  = exp_aok;
      if (exp_aok && exp_dok) n_coincide++;
      rhs      = bus.rvalid && exp_rrdy;
      was_full = m_buf_full;
      if (rhs && r_pend.size() > 0) void'(r_pend.pop_front());
      if (REG_MODE) begin
         if (was_full) m_buf_full = 1'b0;
         else if (rhs && acc_q.size() > 0) m_buf_full = 1'b1;
      end
      if (exp_dok && acc_q.size() > 0) void'(acc_q.pop_front());
      if (exp_aok) begin
         acc_q.push_back('{bus.inst_sram_addr, bus.inst_sram_size});
         m_busy    = 1'b1;
         m_ar_addr = bus.inst_sram_addr;
         m_ar_size = bus.inst_sram_size;
      end else if (m_busy && bus.arready) begin
         m_busy = 1'b0;
         r_pend.push_back('{m_ar_addr, cyc + r_lat});
      end

      @(posedge clk);
      #1;
      cyc++;
      bus.arready = (ar_stall == 0);
      if (ar_stall > 0) ar_stall--;
      if (r_pend.size() > 0 && r_pend[0].t <= cyc) begin
         bus.rvalid = 1'b1;
         bus.rdata  = mem(r_pend[0].addr);
      end else begin
         bus.rvalid = 1'b0;
         bus.rdata  = $urandom;
      end
   endtask

   task automatic fetch(logic [31:0] a, logic [1:0] s);
      drive_req(1'b1, a, s);
      acc_now = 1'b0;
      for (int i = 0; i < 60 && !acc_now; i++) tick();
      chk("fetch_accept", acc_now, 1'b1);
      drive_req(1'b0, $urandom, 2'd2);
   endtask

   task automatic drain();
      drive_req(1'b0, $urandom, 2'd2);
      for (int i = 0; i < 300 && (acc_q.size() > 0 || m_busy || r_pend.size() > 0); i++) tick();
      chk("drain_left", acc_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; ar_stall = 0; r_lat = 2; n_coincide = 0;
      m_busy = 1'b0; m_buf_full = 1'b0; m_ar_addr = '0; m_ar_size = '0;
      reset = 1'b1;
      drive_req(1'b1, 32'h1c00_0000, 2'd2);
      bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rdata = 32'hdead_beef;
      bus.rid = 4'h0; bus.rresp = 2'b00; bus.rlast = 1'b1;

      // reset values
      #12;
      chk("rst_addr_ok", bus.inst_sram_addr_ok, 1'b0);
      chk("rst_data_ok", bus.inst_sram_data_ok, 1'b0);
      chk("rst_rdata", bus.inst_sram_rdata, 32'h0);
      chk("rst_arvalid", bus.arvalid, 1'b0);
      chk("rst_araddr", bus.araddr, 32'h0);
      chk("rst_rready", bus.rready, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      drive_req(1'b0, 32'h0, 2'd2);

      // single fetch, R two cycles after AR
      r_lat = 2;
      fetch(32'h1c00_0000, 2'd2);
      drain();

      // AR stalled five cycles while IF keeps changing the address
      ar_stall = 5;
      fetch(32'h1c00_0004, 2'd2);
      for (int i = 0; i < 5; i++) begin
         drive_req(1'b1, {$urandom, 2'b00} >> 2 << 2, 2'd2);
         tick();
      end
      drain();

      // three back-to-back with slow R: third held until first data_ok
      r_lat = 10;
      for (int i = 0; i < 3; i++) fetch(32'h1c00_0100 + 32'(4 * i), 2'd2);
      drain();

      // same-cycle acceptance and return
      r_lat = 1;
      fetch(32'h1c00_0200, 2'd2);
      fetch(32'h1c00_0204, 2'd2);
      fetch(32'h1c00_0208, 2'd2);
      drain();

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         drive_req(($urandom % 3) != 0, {$urandom % 32'h4000_0000, 2'b00}, 2'($urandom % 3));
         if (ar_stall == 0 && ($urandom % 6) == 0) ar_stall = $urandom % 4;
         r_lat = $urandom % 4;
         tick();
      end
      drain();
      chk("coincide_seen", n_coincide > 0, 1'b1);

      // asynchronous reset while AR is pending with one outstanding
      ar_stall = 4;
      fetch(32'h1c00_0300, 2'd2);
      drive_req(1'b1, 32'h1c00_0304, 2'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_arvalid", bus.arvalid, 1'b0);
      chk("arst_addr_ok", bus.inst_sram_addr_ok, 1'b0);
      chk("arst_data_ok", bus.inst_sram_data_ok, 1'b0);
      chk("arst_araddr", bus.araddr, 32'h0);
      acc_q.delete(); r_pend.delete();
      m_busy = 1'b0; m_buf_full = 1'b0; ar_stall = 0;
      drive_req(1'b0, 32'h0, 2'd2);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bus.arready = 1'b1; bus.rvalid = 1'b0;
      tick();
      r_lat = 2;
      fetch(32'h1c00_0000, 2'd2);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
